// File: rtl/peripheral_gpio_pkg.sv
// peripheral_gpio_pkg: default widths and debounce state type for the GPIO input conditioner
package peripheral_gpio_pkg;
  localparam int GPIO_WIDTH  = 32;
  localparam int CNT_WIDTH   = 16;
  localparam int PRE_WIDTH   = 16;
  localparam int SYNC_STAGES = 2;
  typedef enum logic {STABLE, PENDING} debounce_state_t;
endpackage

// File: rtl/peripheral_gpio_debounce_bit.sv
// peripheral_gpio_debounce_bit: one pad bit -- synchronizer, debounce counter, optional edge pulses
// Ports: clk, rst_n (sync, active-low), pad_i (async level), tick_i (shared sample tick),
//   bypass_i, threshold_i (ticks), ext_pad_o (filtered), rise_o/fall_o (one-cycle edge pulses).
// Macro PERIPHERAL_GPIO_DEBOUNCE_EDGE_EN enables the edge registers; otherwise rise_o/fall_o are 0.
module peripheral_gpio_debounce_bit #(
  parameter int CNT_WIDTH   = peripheral_gpio_pkg::CNT_WIDTH,
  parameter int SYNC_STAGES = peripheral_gpio_pkg::SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pad_i,
  input  logic                 tick_i,
  input  logic                 bypass_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  output logic                 ext_pad_o,
  output logic                 rise_o,
  output logic                 fall_o
);
  import peripheral_gpio_pkg::*;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic ext_q, ext_d, s, accept;
  debounce_state_t state;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    s = sync_q[SYNC_STAGES-1];
    state = (s == ext_q) ? STABLE : PENDING;
    accept = bypass_i || (state == PENDING && tick_i && cnt_q >= threshold_i);
    ext_d = accept ? s : ext_q;
    // a glitch returning to the accepted level clears the count on the very next cycle
    cnt_d = (bypass_i || state == STABLE || accept) ? '0 :
            (tick_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    sync_q <= !rst_n ? '0 : sync_d;
    cnt_q  <= !rst_n ? '0 : cnt_d;
    ext_q  <= !rst_n ? 1'b0 : ext_d;
  end
  assign ext_pad_o = ext_q;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    rise_d = ext_d & ~ext_q;
    fall_d = ~ext_d & ext_q;
  end
  always_ff @(posedge clk) begin
    rise_q <= !rst_n ? 1'b0 : rise_d;
    fall_q <= !rst_n ? 1'b0 : fall_d;
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/peripheral_gpio_debounce.sv
// peripheral_gpio_debounce: synchronize and debounce raw pads ahead of peripheral_gpio_wb
// Ports: wb_clk_i, wb_rst_i (sync, active-low), pad_i (raw), prescale_i (tick every prescale_i+1),
//   threshold_i (debounce ticks), bypass_i (per-bit), ext_pad_o (filtered), rise_o/fall_o (edges).
// Macro PERIPHERAL_GPIO_DEBOUNCE_EDGE_EN enables rise_o/fall_o; otherwise they read 0.
module peripheral_gpio_debounce #(
  parameter int GPIO_WIDTH  = peripheral_gpio_pkg::GPIO_WIDTH,
  parameter int CNT_WIDTH   = peripheral_gpio_pkg::CNT_WIDTH,
  parameter int PRE_WIDTH   = peripheral_gpio_pkg::PRE_WIDTH,
  parameter int SYNC_STAGES = peripheral_gpio_pkg::SYNC_STAGES
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [GPIO_WIDTH-1:0] pad_i,
  input  logic [PRE_WIDTH-1:0]  prescale_i,
  input  logic [CNT_WIDTH-1:0]  threshold_i,
  input  logic [GPIO_WIDTH-1:0] bypass_i,
  output logic [GPIO_WIDTH-1:0] ext_pad_o,
  output logic [GPIO_WIDTH-1:0] rise_o,
  output logic [GPIO_WIDTH-1:0] fall_o
);
  logic [PRE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic tick;
  always_comb begin
    // >= so that lowering prescale_i below pcnt forces an immediate wrap
    tick = pcnt_q >= prescale_i;
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end
  always_ff @(posedge wb_clk_i) pcnt_q <= !wb_rst_i ? '0 : pcnt_d;
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    peripheral_gpio_debounce_bit #(.CNT_WIDTH(CNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_bit (
      .clk(wb_clk_i), .rst_n(wb_rst_i), .pad_i(pad_i[i]), .tick_i(tick),
      .bypass_i(bypass_i[i]), .threshold_i(threshold_i),
      .ext_pad_o(ext_pad_o[i]), .rise_o(rise_o[i]), .fall_o(fall_o[i])
    );
  end
endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// tb_peripheral_gpio_debounce: table vectors plus corner sequences, expectations queued and popped
module tb_peripheral_gpio_debounce;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  typedef struct {
    string nm;
    logic [31:0] ext, rise, fall;
  } exp_t;
  typedef struct {
    logic [31:0] pad;
    logic [15:0] thr;
    int w;
    logic [31:0] ext, rise, fall;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] pad, bypass, ext, rise, fall;
  logic [15:0] pre, thr;
  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  vec_t tbl[11];
  always #5 clk = ~clk;
  peripheral_gpio_debounce dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .pad_i(pad), .prescale_i(pre), .threshold_i(thr),
    .bypass_i(bypass), .ext_pad_o(ext), .rise_o(rise), .fall_o(fall)
  );
  function automatic logic [31:0] er(input logic [31:0] x);
    return EDGE ? x : 32'h0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask
  task automatic push(input string nm, input logic [31:0] e, input logic [31:0] r, input logic [31:0] f);
    exp_t x;
    x.nm = nm; x.ext = e; x.rise = r; x.fall = f;
    q.push_back(x);
  endtask
  task automatic pop_chk();
    exp_t x;
    if (q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      x = q.pop_front();
      chk({x.nm, "_ext"}, ext, x.ext);
      chk({x.nm, "_rise"}, rise, x.rise);
      chk({x.nm, "_fall"}, fall, x.fall);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int first, fall_cnt, fall_at;
    logic h[32];
    logic cur, prev;
    tbl[0]  = '{32'hFFFF_FFFF, 16'd0, 2, 32'h0,         32'h0,                32'h0};
    tbl[1]  = '{32'hFFFF_FFFF, 16'd0, 1, 32'hFFFF_FFFF, er(32'hFFFF_FFFF),    32'h0};
    tbl[2]  = '{32'hFFFF_FFFF, 16'd0, 1, 32'hFFFF_FFFF, 32'h0,                32'h0};
    tbl[3]  = '{32'h0000_00F0, 16'd0, 3, 32'h0000_00F0, 32'h0,                er(32'hFFFF_FF0F)};
    tbl[4]  = '{32'h0000_00F0, 16'd0, 1, 32'h0000_00F0, 32'h0,                32'h0};
    tbl[5]  = '{32'h0,         16'd0, 2, 32'h0000_00F0, 32'h0,                32'h0};
    tbl[6]  = '{32'h0,         16'd0, 1, 32'h0,         32'h0,                er(32'h0000_00F0)};
    tbl[7]  = '{32'h5,         16'd0, 3, 32'h5,         er(32'h5),            32'h0};
    tbl[8]  = '{32'h5,         16'd0, 1, 32'h5,         32'h0,                32'h0};
    tbl[9]  = '{32'h0,         16'd1, 3, 32'h5,         32'h0,                32'h0};
    tbl[10] = '{32'h0,         16'd1, 1, 32'h0,         32'h0,                er(32'h5)};
    rst_n = 1'b0; pad = 32'hFFFF_FFFF; pre = 16'd0; thr = 16'd0; bypass = 32'h0;
    push("reset", 32'h0, 32'h0, 32'h0);
    cyc(4);
    pop_chk();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      pad = tbl[i].pad; thr = tbl[i].thr;
      push($sformatf("vec%0d", i), tbl[i].ext, tbl[i].rise, tbl[i].fall);
      cyc(tbl[i].w);
      pop_chk();
    end
    thr = 16'd5; pad = 32'h1;
    push("dl7", 32'h0, 32'h0, 32'h0); cyc(7); pop_chk();
    push("dl8", 32'h1, er(32'h1), 32'h0); cyc(1); pop_chk();
    push("dl9", 32'h1, 32'h0, 32'h0); cyc(1); pop_chk();
    for (int c = 0; c < 14; c++) begin
      pad = (c < 4) ? 32'h9 : 32'h1;
      push($sformatf("glitch%0d", c), 32'h1, 32'h0, 32'h0);
      cyc(1);
      pop_chk();
    end
    pre = 16'd3; thr = 16'd2; pad = 32'h81;
    push("pre_settle", 32'h81, 32'h0, 32'h0); cyc(30); pop_chk();
    pad = 32'h01; first = 0; fall_cnt = 0; fall_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (first == 0 && !ext[7]) first = k;
      if (fall[7]) begin fall_cnt++; fall_at = k; end
    end
    chk("pre_not_early", 32'(first >= 11), 32'h1);
    chk("pre_not_late", 32'(first <= 14), 32'h1);
    chk("pre_fall_cnt", 32'(fall_cnt), EDGE ? 32'h1 : 32'h0);
    chk("pre_fall_at", 32'(fall_at), EDGE ? 32'(first) : 32'h0);
    pre = 16'd0; thr = 16'd100; bypass = 32'h1; pad = 32'h0;
    push("byp_settle", 32'h0, 32'h0, 32'h0); cyc(5); pop_chk();
    for (int c = 0; c < 32; c++) begin
      h[c] = ((c / 4) % 2) == 1;
      pad = {30'h0, h[c], h[c]};
      cur = (c >= 2) ? h[c-2] : 1'b0;
      prev = (c >= 3) ? h[c-3] : 1'b0;
      push($sformatf("byp%0d", c), {31'h0, cur}, er({31'h0, cur & ~prev}), er({31'h0, prev & ~cur}));
      cyc(1);
      pop_chk();
    end
    bypass = 32'h0; thr = 16'd3; pad = 32'h0;
    cyc(10);
    push("rst_pre", 32'h0, 32'h0, 32'h0); pop_chk();
    pad = 32'h2; cyc(3);
    rst_n = 1'b0;
    push("rst_mid", 32'h0, 32'h0, 32'h0); cyc(1); pop_chk();
    rst_n = 1'b1;
    push("rst_wait", 32'h0, 32'h0, 32'h0); cyc(5); pop_chk();
    push("rst_acc", 32'h2, er(32'h2), 32'h0); cyc(1); pop_chk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/peripheral_gpio_debounce.md
# peripheral_gpio_debounce

Input-conditioning stage placed directly upstream of `peripheral_gpio_wb`: it takes raw, asynchronous pad levels, synchronizes them into the `wb_clk_i` domain, and debounces each bit. The filtered result drives the GPIO core's `ext_pad_i`. Optionally, it also emits single-cycle rise/fall event pulses for interrupt or capture logic.

## Interface
Parameters:
- `GPIO_WIDTH`, 32, number of pad bits
- `CNT_WIDTH`, 16, width of the per-bit debounce counter and of `threshold_i`
- `PRE_WIDTH`, 16, width of the shared sample prescaler and of `prescale_i`
- `SYNC_STAGES`, 2, synchronizer flops per bit (min 2)

Ports:
- `wb_clk_i`  in  1  single clock
- `wb_rst_i`  in  1  reset, synchronous, active-low (0 = reset)
- `pad_i`  in  GPIO_WIDTH  raw asynchronous pad levels
- `prescale_i`  in  PRE_WIDTH  sample tick every `prescale_i`+1 cycles
- `threshold_i`  in  CNT_WIDTH  debounce length in ticks
- `bypass_i`  in  GPIO_WIDTH  per-bit debounce bypass
- `ext_pad_o`  out  GPIO_WIDTH  filtered levels, feeds `peripheral_gpio_wb.ext_pad_i`
- `rise_o`  out  GPIO_WIDTH  one-cycle pulse on filtered 0→1
- `fall_o`  out  GPIO_WIDTH  one-cycle pulse on filtered 1→0

## Operation
- Synchronizer: `SYNC_STAGES`-deep flop chain per bit. The last stage is `s[i]`.
- Prescaler:
  - `pcnt` increments every cycle.
  - When `pcnt >= prescale_i`, `tick` = 1 and `pcnt` goes to 0.
  - With `prescale_i` = 0, `tick` is asserted every cycle.
  - Lowering `prescale_i` below the current `pcnt` forces an immediate tick and wrap.
- Per-bit debounce, two states:
  - STABLE: `s[i] == ext_pad_o[i]`. `cnt[i]` is held at 0.
  - PENDING: `s[i] != ext_pad_o[i]`.
  - On each `tick` in PENDING: if `cnt[i] >= threshold_i`, then `ext_pad_o[i] <= s[i]` and `cnt[i] <= 0`. Otherwise `cnt[i]++`.
  - If `s[i]` returns to `ext_pad_o[i]` before acceptance, `cnt[i]` clears on the next cycle, tick or not. This handles glitch rejection.
  - `cnt[i]` saturates at all-ones and never wraps.
  - A change to `threshold_i` mid-count takes effect on the next tick, using the `>=` compare.
- Bypass: when `bypass_i[i]` = 1, `ext_pad_o[i] <= s[i]` every cycle and `cnt[i]` is held at 0. Clearing bypass resumes normal debouncing from the current levels.
- Edges: `rise_o[i]`/`fall_o[i]` are registered at the same edge at which `ext_pad_o[i]` changes. Each is high for exactly one cycle. Bypassed bits generate edges too.
- Reset (`wb_rst_i` = 0 at a clock edge): all sync flops, `ext_pad_o`, `rise_o`, `fall_o`, `cnt`, and `pcnt` go to 0. Reset asserted mid-debounce discards the pending count. After reset, a pad held at 1 is treated as a new change and is debounced normally.

## Timing
- Latency from a pad change to `ext_pad_o`, with `prescale_i` = 0: `SYNC_STAGES` + `threshold_i` + 1 cycles. With defaults and threshold 0, this is 3 cycles.
- With prescaling, latency is up to `SYNC_STAGES` + (`threshold_i`+1)·(`prescale_i`+1) cycles, depending on tick phase.
- A pad pulse narrower than (`threshold_i`+1) ticks after synchronization never reaches `ext_pad_o`.
- No handshakes. All outputs are registered, so there are no combinational paths from inputs to outputs.

## Configuration
- `PERIPHERAL_GPIO_DEBOUNCE_EDGE_EN`:
  - Defined: edge registers and `rise_o`/`fall_o` behave as above.
  - Undefined: the edge logic is removed and `rise_o`/`fall_o` are tied to constant 0.
  - `ext_pad_o` behaviour is identical in both cases.

## Structure
- Shared package `peripheral_gpio_pkg` holds the default width constants (`GPIO_WIDTH`, `CNT_WIDTH`, `PRE_WIDTH`, `SYNC_STAGES`) and the `debounce_state_t` enum (STABLE, PENDING).
- Sub-module `peripheral_gpio_debounce_bit` contains one bit's synchronizer, counter, state, and edge logic. It is instantiated `GPIO_WIDTH` times in a generate loop.
- The prescaler is shared and lives in the top level.

## Test plan
- Reset: hold `wb_rst_i`=0 for 4 cycles with `pad_i`=32'hFFFF_FFFF. All outputs are 0 during reset. With threshold 0 and prescale 0, `ext_pad_o` = 32'hFFFF_FFFF exactly 3 cycles after release, and `rise_o` = 32'hFFFF_FFFF for one cycle.
- Debounce length: `prescale_i`=0, `threshold_i`=5, `pad_i[0]` 0→1 and held. `ext_pad_o[0]` rises exactly 8 cycles later, with a single `rise_o[0]` pulse.
- Glitch reject: `threshold_i`=5, `pad_i[3]` high for 4 cycles then low. `ext_pad_o[3]` stays 0 and `rise_o`/`fall_o` stay 0.
- Prescaler: `prescale_i`=3, `threshold_i`=2, `pad_i[7]` 1→0 after a settled 1. `ext_pad_o[7]` falls within 2+3·4 = 14 cycles and not before 2+2·4+1 = 11 cycles. `fall_o[7]` pulses once.
- Bypass: `bypass_i`=32'h0000_0001, `threshold_i`=100, toggle `pad_i[0]` every 4 cycles. `ext_pad_o[0]` follows with a 3-cycle lag. Bit 1, toggled the same way, never changes.
- Macro off: build without `PERIPHERAL_GPIO_DEBOUNCE_EDGE_EN` and rerun the second scenario. `ext_pad_o` timing is unchanged and `rise_o` = `fall_o` = 0 throughout.
